quad_encoder_cntr: RTL and testbench

Quadrature decoder and 24-bit tick counter for one wheel encoder. It produces the feedback `i_EncCntL/R` and `i_WhlDirL/R` signals consumed by the motor controller and its PID loop. It also honours the controller's `o_zero_encoders` request. One instance per wheel; it runs on the 256 kHz master PWM clock.

---
 rtl/enc_pkg.sv | 42 ++++
 rtl/enc_input_filter.sv | 83 ++++++++
 rtl/quad_encoder_cntr.sv | 118 +++++++++++
 tb/tb_quad_encoder_cntr.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg
// Shared types and helpers for the quadrature encoder counter.
//   DIR_FWD / DIR_REV : values carried on o_WhlDir
//   ENC_CNT_W         : width of the tick counter
//   enc_ab_t          : 2-bit quadrature state {A,B}
//   enc_tr_e          : classification of a prev->cur state change
//   enc_decode()      : classifies a state change
package enc_pkg;

  localparam logic DIR_FWD   = 1'b1;
  localparam logic DIR_REV   = 1'b0;
  localparam int   ENC_CNT_W = 24;

  typedef logic [1:0] enc_ab_t;

  typedef enum logic [1:0] {
    NONE,
    FWD,
    REV,
    ILLEGAL
  } enc_tr_e;

  // Position of a state on the forward cycle 00->01->11->10 (Gray to binary).
  function automatic logic [1:0] enc_phase(input enc_ab_t ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic enc_tr_e enc_decode(input enc_ab_t prev, input enc_ab_t cur);
    enc_tr_e tr;
    if (prev == cur) begin
      tr = NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      tr = ILLEGAL;
    end else if (enc_phase(cur) == enc_phase(prev) + 2'd1) begin
      tr = FWD;
    end else begin
      tr = REV;
    end
    return tr;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// enc_input_filter
// Two-flop synchronizer for one encoder channel, optionally followed by a
// stable-level filter (compiled in with ENC_GLITCH_FILTER_EN).
//   i_Clock  : master clock
//   i_Rst_n  : async active-low reset
//   i_pin    : raw asynchronous encoder pin
//   o_level  : synchronized (and filtered) level
//   o_valid  : o_level reflects a real pin sample, not the reset value
module enc_input_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_valid
);

  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("enc_input_filter: FILT_LEN must be 1..15");
  end

  logic sync1_q, sync2_q;
  logic vld1_q, vld2_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
    end else begin
      sync1_q <= i_pin;
      sync2_q <= sync1_q;
      vld1_q  <= 1'b1;
      vld2_q  <= vld1_q;
    end
  end

`ifdef ENC_GLITCH_FILTER_EN
  localparam logic [3:0] LEN = 4'(FILT_LEN);

  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rem;
  logic       settled_q, settled_d;

  // cnt_q counts down the samples still needed; 0 means "idle", so the first
  // differing sample starts from the full length.
  always_comb begin
    filt_d    = filt_q;
    cnt_d     = 4'd0;
    rem       = (cnt_q == 4'd0) ? LEN : cnt_q;
    if (sync2_q != filt_q) begin
      if (rem == 4'd1) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = rem - 4'd1;
      end
    end
    settled_d = settled_q | (vld2_q & (sync2_q == filt_q));
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      filt_q    <= 1'b0;
      cnt_q     <= 4'd0;
      settled_q <= 1'b0;
    end else begin
      filt_q    <= filt_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
    end
  end

  assign o_level = filt_q;
  assign o_valid = settled_q;
`else
  assign o_level = sync2_q;
  assign o_valid = vld2_q;
`endif

endmodule

// File: rtl/quad_encoder_cntr.sv
// quad_encoder_cntr
// x4 quadrature decoder with a 24-bit wrapping tick counter for one wheel.
// Optional glitch filter on A/B: macro ENC_GLITCH_FILTER_EN.
//   i_Clock  : 256 kHz master clock
//   i_Rst_n  : async active-low reset
//   i_EncA/B : raw encoder channels
//   i_Zero   : synchronous clear of count and error flag
//   o_EncCnt : number of valid transitions (magnitude only)
//   o_WhlDir : direction of last valid transition (1 = forward)
//   o_Tick   : one-cycle pulse per counted transition
//   o_Err    : sticky illegal-transition flag
module quad_encoder_cntr
  import enc_pkg::*;
#(
  parameter int unsigned FILT_LEN   = 3,
  parameter logic        DIR_INVERT = 1'b0
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_EncA,
  input  logic                 i_EncB,
  input  logic                 i_Zero,
  output logic [ENC_CNT_W-1:0] o_EncCnt,
  output logic                 o_WhlDir,
  output logic                 o_Tick,
  output logic                 o_Err
);

  logic    a_lvl, b_lvl, a_vld, b_vld;
  enc_ab_t cur_ab;

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_pin   (i_EncA),
    .o_level (a_lvl),
    .o_valid (a_vld)
  );

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_pin   (i_EncB),
    .o_level (b_lvl),
    .o_valid (b_vld)
  );

  assign cur_ab = {a_lvl, b_lvl};

  enc_ab_t              prev_q, prev_d;
  logic                 primed_q, primed_d;
  logic [ENC_CNT_W-1:0] cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic                 tick_q, tick_d;
  logic                 err_q, err_d;
  enc_tr_e              tr;

  always_comb begin
    prev_d   = prev_q;
    primed_d = primed_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    tick_d   = 1'b0;
    err_d    = err_q;
    tr       = enc_decode(prev_q, cur_ab);

    // Until both channels carry a real sample, the pair is just the reset
    // value; priming on it would turn a wheel resting at 11 into an event.
    if (!primed_q) begin
      if (a_vld && b_vld) begin
        prev_d   = cur_ab;
        primed_d = 1'b1;
      end
    end else begin
      prev_d = cur_ab;
      case (tr)
        FWD, REV: begin
          cnt_d  = cnt_q + ENC_CNT_W'(1);
          dir_d  = ((tr == FWD) != DIR_INVERT) ? DIR_FWD : DIR_REV;
          tick_d = 1'b1;
        end
        ILLEGAL: err_d = 1'b1;
        default: ;
      endcase
    end

    // Zero overrides count, tick and error but lets direction track.
    if (i_Zero) begin
      cnt_d  = '0;
      tick_d = 1'b0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      prev_q   <= 2'b00;
      primed_q <= 1'b0;
      cnt_q    <= '0;
      dir_q    <= DIR_FWD;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
    end
  end

  assign o_EncCnt = cnt_q;
  assign o_WhlDir = dir_q;
  assign o_Tick   = tick_q;
  assign o_Err    = err_q;

endmodule

// File: tb/tb_quad_encoder_cntr.sv
// tb_quad_encoder_cntr
// Directed bench for quad_encoder_cntr. Filter-specific steps are included
// when ENC_GLITCH_FILTER_EN is defined (FILT_LEN = 3).
module tb_quad_encoder_cntr;
  import enc_pkg::*;

`ifdef ENC_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enc_a = 1'b0;
  logic                 enc_b = 1'b0;
  logic                 zero  = 1'b0;
  logic [ENC_CNT_W-1:0] enc_cnt;
  logic                 whl_dir;
  logic                 tick;
  logic                 err;

  int n_assert = 0;
  int n_fail   = 0;
  int tick_cnt = 0;

  quad_encoder_cntr #(.FILT_LEN(3), .DIR_INVERT(1'b0)) dut (
    .i_Clock  (clk),
    .i_Rst_n  (rst_n),
    .i_EncA   (enc_a),
    .i_EncB   (enc_b),
    .i_Zero   (zero),
    .o_EncCnt (enc_cnt),
    .o_WhlDir (whl_dir),
    .o_Tick   (tick),
    .o_Err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (tick) tick_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] ab);
    enc_a = ab[1];
    enc_b = ab[0];
  endtask

  task automatic step(input logic [1:0] ab);
    drive(ab);
    wait_neg(8);
  endtask

  task automatic zero_pulse();
    zero = 1'b1;
    wait_neg(1);
    zero = 1'b0;
  endtask

  initial begin
    // Reset with the wheel resting at 11.
    drive(2'b11);
    wait_neg(2);
    chk("rst_cnt",  enc_cnt, 0);
    chk("rst_dir",  whl_dir, 1);
    chk("rst_tick", tick,    0);
    chk("rst_err",  err,     0);
    rst_n = 1'b1;
    wait_neg(10);
    chk("prime_cnt",  enc_cnt,  0);
    chk("prime_err",  err,      0);
    chk("prime_tick", tick_cnt, 0);

    // Forward 11->10->00->01->11, first step checks latency.
    tick_cnt = 0;
    drive(2'b10);
    wait_neg(LAT - 1);
    chk("lat_before", enc_cnt, 0);
    wait_neg(1);
    chk("lat_after",  enc_cnt, 1);
    chk("lat_tick",   tick,    1);
    wait_neg(8 - LAT);
    step(2'b00);
    step(2'b01);
    step(2'b11);
    chk("fwd_cnt",   enc_cnt,  4);
    chk("fwd_dir",   whl_dir,  1);
    chk("fwd_ticks", tick_cnt, 4);
    chk("fwd_err",   err,      0);

    // Reverse: clear, walk back to 00, clear, then 00->10->11->01->00.
    zero_pulse();
    chk("zero_cnt", enc_cnt, 0);
    step(2'b01);
    step(2'b00);
    chk("rev_pre_cnt", enc_cnt, 2);
    chk("rev_pre_dir", whl_dir, 0);
    zero_pulse();
    tick_cnt = 0;
    step(2'b10);
    step(2'b11);
    step(2'b01);
    step(2'b00);
    chk("rev_cnt",   enc_cnt,  4);
    chk("rev_dir",   whl_dir,  0);
    chk("rev_err",   err,      0);
    chk("rev_ticks", tick_cnt, 4);

    // Illegal 00->11, then clear, then a legal step from the new state.
    step(2'b11);
    chk("ill_cnt", enc_cnt, 4);
    chk("ill_err", err,     1);
    chk("ill_dir", whl_dir, 0);
    zero_pulse();
    chk("ill_zero_err", err,     0);
    chk("ill_zero_cnt", enc_cnt, 0);
    step(2'b10);
    chk("post_ill_cnt", enc_cnt, 1);
    chk("post_ill_dir", whl_dir, 1);

    // Wrap from a backdoor preload.
    force dut.cnt_q = 24'hFFFFFE;
    wait_neg(1);
    release dut.cnt_q;
    chk("wrap_preload", enc_cnt, 32'hFFFFFE);
    step(2'b00);
    chk("wrap_top",  enc_cnt, 32'hFFFFFF);
    step(2'b01);
    chk("wrap_zero", enc_cnt, 0);
    chk("wrap_err",  err,     0);

    // Zero on the same edge as a valid reverse transition.
    step(2'b11);
    chk("coll_pre_cnt", enc_cnt, 1);
    chk("coll_pre_dir", whl_dir, 1);
    drive(2'b01);
    wait_neg(LAT - 1);
    zero = 1'b1;
    wait_neg(1);
    zero = 1'b0;
    chk("coll_cnt",  enc_cnt, 0);
    chk("coll_tick", tick,    0);
    chk("coll_dir",  whl_dir, 0);
    wait_neg(6);

    // Zero held high across a transition.
    zero = 1'b1;
    tick_cnt = 0;
    step(2'b00);
    chk("hold_cnt",   enc_cnt,  0);
    chk("hold_ticks", tick_cnt, 0);
    zero = 1'b0;
    wait_neg(2);

`ifdef ENC_GLITCH_FILTER_EN
    // 2-clock pulse on A is discarded.
    tick_cnt = 0;
    drive(2'b10);
    wait_neg(2);
    drive(2'b00);
    wait_neg(10);
    chk("glitch_cnt",   enc_cnt,  0);
    chk("glitch_ticks", tick_cnt, 0);
    // Stable change counted 5 edges after sampling.
    drive(2'b10);
    wait_neg(LAT - 1);
    chk("filt_before", enc_cnt, 0);
    wait_neg(1);
    chk("filt_after",  enc_cnt, 1);
    chk("filt_dir",    whl_dir, 0);
    wait_neg(8);
    step(2'b00);
    chk("filt_cnt2", enc_cnt, 2);
    zero_pulse();
`endif

    // Async reset mid-transition.
    step(2'b10);
    step(2'b01);
    chk("arst_pre_cnt", enc_cnt, 1);
    chk("arst_pre_err", err,     1);
    chk("arst_pre_dir", whl_dir, 0);
    drive(2'b00);
    wait_neg(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt",  enc_cnt, 0);
    chk("arst_dir",  whl_dir, 1);
    chk("arst_tick", tick,    0);
    chk("arst_err",  err,     0);
    wait_neg(2);
    rst_n = 1'b1;
    tick_cnt = 0;
    wait_neg(10);
    chk("arst_prime_cnt",   enc_cnt,  0);
    chk("arst_prime_ticks", tick_cnt, 0);
    step(2'b01);
    chk("arst_fwd_cnt", enc_cnt, 1);
    chk("arst_fwd_dir", whl_dir, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
